piso_serializer: RTL and testbench

- Parallel-in, serial-out framer that sits directly upstream of the 4-stage serial shift register chain and drives its serial data input.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock with framing strobes.
- Back-to-back words stream with no idle bubble.

---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_bit_counter.sv | 46 ++++
 rtl/piso_serializer.sv | 105 ++++++++++
 tb/tb_piso_serializer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out framer.
package piso_pkg;

  // Framer state: idle waiting for a word, or shifting one out.
  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // Bit-order selector values for the LSB_FIRST parameter.
  localparam bit MSB_FIRST = 1'b0;
  localparam bit LSB_FIRST = 1'b1;

  // Width of the bit counter that indexes a word of the given width.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking which bit of a word is on the serial output.
// Loads to Width-1 at the start of a word and counts down to 0 on the last bit.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned Width = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic is_first_o,
  output logic is_last_o
);

  localparam int unsigned CntW = cnt_w(Width);
  localparam logic [CntW-1:0] MaxVal = CntW'(Width - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Load takes priority over decrement; the counter rests at 0 when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = MaxVal;
    end else if (dec_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Position flags decoded from the registered count only.
  always_comb begin
    is_first_o = (cnt_q == MaxVal);
    is_last_o  = (cnt_q == '0);
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out framer: takes a WIDTH-bit word over valid/ready and
// emits it one bit per clock with first/last-bit strobes. A new word can be
// accepted during the last bit of the current one, so words stream without gaps.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  import piso_pkg::*;

  // Bit position that is presented on sout.
  localparam int unsigned OutIdx = (LSB_FIRST == piso_pkg::LSB_FIRST) ? 0 : WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             cnt_load, cnt_dec;
  logic             is_first, is_last;
  logic             xfer;

  piso_bit_counter #(
    .Width(WIDTH)
  ) u_bit_counter (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (cnt_load),
    .dec_i     (cnt_dec),
    .is_first_o(is_first),
    .is_last_o (is_last)
  );

  // Ready depends on registered state only: always when idle, else on the last bit.
  always_comb begin
    din_ready = (state_q == StIdle) || ((state_q == StShift) && is_last);
    xfer      = din_valid && din_ready;
  end

  // Next-state logic: load, shift toward the output end, reload, or drain to idle.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          shreg_d  = din;
          cnt_load = 1'b1;
          state_d  = StShift;
        end
      end
      StShift: begin
        if (!is_last) begin
          if (LSB_FIRST == piso_pkg::LSB_FIRST) begin
            shreg_d = shreg_q >> 1;
          end else begin
            shreg_d = shreg_q << 1;
          end
          cnt_dec = 1'b1;
        end else if (xfer) begin
          shreg_d  = din;
          cnt_load = 1'b1;
        end else begin
          shreg_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        shreg_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // Serial outputs decoded from registered state.
  always_comb begin
    sout_valid  = (state_q == StShift);
    sout        = sout_valid ? shreg_q[OutIdx] : 1'b0;
    frame_start = sout_valid && is_first;
    frame_end   = sout_valid && is_last;
    busy        = sout_valid;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances driven in parallel,
// checked against a queue-of-pending-bits model, plus a 4-stage chain on sout.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] din = 4'h0;
  logic       din_valid = 1'b0;

  logic m_ready, m_sout, m_valid, m_fs, m_fe, m_busy;
  logic l_ready, l_sout, l_valid, l_fs, l_fe, l_busy;
  logic [5:0] vm, vl;
  logic [3:0] chain_q;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic b;
    logic s;
    logic e;
  } ent_t;

  // Model: bits still to appear on sout; entry 0 is the one currently shown.
  ent_t qm[$];
  ent_t ql[$];
  logic hist[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (m_ready),
    .sout       (m_sout),
    .sout_valid (m_valid),
    .frame_start(m_fs),
    .frame_end  (m_fe),
    .busy       (m_busy)
  );

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (l_ready),
    .sout       (l_sout),
    .sout_valid (l_valid),
    .frame_start(l_fs),
    .frame_end  (l_fe),
    .busy       (l_busy)
  );

  assign vm = {m_sout, m_valid, m_fs, m_fe, m_busy, m_ready};
  assign vl = {l_sout, l_valid, l_fs, l_fe, l_busy, l_ready};

  // Downstream 4-stage serial shift register fed by the MSB-first sout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain_q <= 4'h0;
    else        chain_q <= {chain_q[2:0], m_sout};
  end

  // Expected {sout, sout_valid, frame_start, frame_end, busy, din_ready}.
  function automatic logic [5:0] exp_vec(input bit lsb);
    ent_t h;
    int   n;
    n = lsb ? ql.size() : qm.size();
    if (n == 0) return 6'b000001;
    h = lsb ? ql[0] : qm[0];
    return {h.b, 1'b1, h.s, h.e, 1'b1, (n <= 1)};
  endfunction

  function automatic logic exp_chain();
    int n;
    n = hist.size();
    return (n >= 5) ? hist[n-5] : 1'b0;
  endfunction

  function automatic void model_clear();
    qm.delete();
    ql.delete();
    hist.delete();
  endfunction

  // One clock edge of the model: accept if at most one bit remains, drop the shown bit.
  function automatic void model_edge(input logic [3:0] d, input logic v);
    bit         acc;
    ent_t       t;
    logic [5:0] e;
    if (!reset) begin
      model_clear();
      return;
    end
    acc = v && (qm.size() <= 1);
    if (qm.size() > 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (acc) begin
      for (int i = 0; i < 4; i++) begin
        t.s = (i == 0);
        t.e = (i == 3);
        t.b = d[3-i];
        qm.push_back(t);
        t.b = d[i];
        ql.push_back(t);
      end
    end
    e = exp_vec(1'b0);
    hist.push_back(e[5]);
  endfunction

  task automatic cycle(input logic [3:0] d, input logic v);
    din       = d;
    din_valid = v;
    @(posedge clk);
    model_edge(d, v);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) cycle(4'h0, 1'b0);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (vm !== 6'b000001) begin
      errors++;
      $display("FAIL reset_msb got %b want %b", vm, 6'b000001);
    end
    checks++;
    if (vl !== 6'b000001) begin
      errors++;
      $display("FAIL reset_lsb got %b want %b", vl, 6'b000001);
    end
    din       = 4'b1011;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (vm !== 6'b000001) begin
      errors++;
      $display("FAIL reset_held got %b want %b", vm, 6'b000001);
    end
    din_valid = 1'b0;
    #1 reset = 1'b1;
    model_clear();
  endtask

  task automatic test_single();
    logic [5:0] em[5];
    logic [5:0] el[5];
    em = '{6'b111010, 6'b010010, 6'b110010, 6'b110111, 6'b000001};
    el = '{6'b111010, 6'b110010, 6'b010010, 6'b110111, 6'b000001};
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1011, (i == 0));
      checks++;
      if (vm !== em[i]) begin
        errors++;
        $display("FAIL single_msb step %0d got %b want %b", i, vm, em[i]);
      end
      checks++;
      if (vl !== el[i]) begin
        errors++;
        $display("FAIL single_lsb step %0d got %b want %b", i, vl, el[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    logic [2:0] got, want;
    seq = 8'b10110110;
    for (int i = 0; i < 9; i++) begin
      cycle((i == 0) ? 4'b1011 : 4'b0110, (i <= 4));
      got  = {m_sout, m_valid, m_ready};
      want = (i < 8) ? {seq[7-i], 1'b1, (i % 4 == 3)} : 3'b001;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b step %0d got %b want %b", i, got, want);
      end
      checks++;
      if (vl !== exp_vec(1'b1)) begin
        errors++;
        $display("FAIL b2b_lsb step %0d got %b want %b", i, vl, exp_vec(1'b1));
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [3:0] first;
    first = 4'b1011;
    for (int i = 0; i < 9; i++) begin
      cycle((i == 0) ? 4'b1011 : 4'b0000, (i <= 4));
      checks++;
      if (vm !== exp_vec(1'b0)) begin
        errors++;
        $display("FAIL busy_model step %0d got %b want %b", i, vm, exp_vec(1'b0));
      end
      if (i < 4) begin
        checks++;
        if (m_sout !== first[3-i]) begin
          errors++;
          $display("FAIL busy_sout step %0d got %b want %b", i, m_sout, first[3-i]);
        end
      end
      if (i == 4) begin
        checks++;
        if ({m_valid, m_fs, m_sout} !== 3'b110) begin
          errors++;
          $display("FAIL busy_accept got %b want %b", {m_valid, m_fs, m_sout}, 3'b110);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] w;
    w = 4'b0110;
    cycle(4'b1011, 1'b1);
    cycle(4'b0000, 1'b0);
    #2 reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (vm !== 6'b000001) begin
      errors++;
      $display("FAIL midreset_msb got %b want %b", vm, 6'b000001);
    end
    checks++;
    if (vl !== 6'b000001) begin
      errors++;
      $display("FAIL midreset_lsb got %b want %b", vl, 6'b000001);
    end
    cycle(4'b0000, 1'b0);
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(w, (i == 0));
      checks++;
      if (vm !== exp_vec(1'b0)) begin
        errors++;
        $display("FAIL postreset_model step %0d got %b want %b", i, vm, exp_vec(1'b0));
      end
      if (i < 4) begin
        checks++;
        if ({m_sout, m_valid, m_fs} !== {w[3-i], 1'b1, (i == 0)}) begin
          errors++;
          $display("FAIL postreset_bit step %0d got %b want %b", i,
                   {m_sout, m_valid, m_fs}, {w[3-i], 1'b1, (i == 0)});
        end
      end
    end
  endtask

  task automatic test_chained();
    logic [3:0] w;
    w = 4'b1011;
    for (int i = 0; i < 9; i++) begin
      cycle(w, (i == 0));
      checks++;
      if (chain_q[3] !== exp_chain()) begin
        errors++;
        $display("FAIL chain_model step %0d got %b want %b", i, chain_q[3], exp_chain());
      end
      if (i >= 4 && i < 8) begin
        checks++;
        if (chain_q[3] !== w[7-i]) begin
          errors++;
          $display("FAIL chain_bit step %0d got %b want %b", i, chain_q[3], w[7-i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] d;
    logic       v;
    for (int i = 0; i < 300; i++) begin
      d = 4'($urandom);
      v = ($urandom_range(0, 3) != 0);
      cycle(d, v);
      checks++;
      if (vm !== exp_vec(1'b0)) begin
        errors++;
        $display("FAIL rand_msb cyc %0d got %b want %b", i, vm, exp_vec(1'b0));
      end
      checks++;
      if (vl !== exp_vec(1'b1)) begin
        errors++;
        $display("FAIL rand_lsb cyc %0d got %b want %b", i, vl, exp_vec(1'b1));
      end
      checks++;
      if (chain_q[3] !== exp_chain()) begin
        errors++;
        $display("FAIL rand_chain cyc %0d got %b want %b", i, chain_q[3], exp_chain());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    drain();
    test_back_to_back();
    drain();
    test_busy_ignore();
    drain();
    test_reset_mid_word();
    drain();
    test_chained();
    drain();
    test_random();
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
